// File: rtl/haar_dwt_1d_ml.sv
// Multi-level 1-D Haar analysis stage: one level per clock on the low band.
// The result is held until downstream takes it.
module haar_dwt_1d_ml #(
  parameter int PIX_W  = 8,
  parameter int N_PIX  = 8,
  parameter int LEVELS = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             levels,
  input  logic [N_PIX*PIX_W-1:0] pixel,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N_PIX*PIX_W-1:0] pix_out,
  output logic                   busy
);

  localparam int VW = N_PIX * PIX_W;
  localparam logic [2:0] LMAX = 3'(LEVELS);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    HOLD
  } state_t;

  state_t          r_state;
  logic [2:0]      r_lvl;
  logic [2:0]      r_depth;
  logic [VW-1:0]   r_work;
  logic [VW-1:0]   r_pix_out;
  logic            r_out_valid;
  logic            r_in_ready;
  logic            r_busy;

  logic [VW-1:0]   w_res [LEVELS];
  logic [VW-1:0]   w_next;
  logic [2:0]      w_depth;

  // Level j works on the top N_PIX>>(j-1) lanes only
  for (genvar j = 0; j < LEVELS; j++) begin : g_lvl
    localparam int M = N_PIX >> j;
    localparam int B = N_PIX - M;
    always_comb begin
      logic [PIX_W-1:0]        a;
      logic [PIX_W-1:0]        b;
      logic [PIX_W:0]          s;
      logic signed [PIX_W:0]   d;
      w_res[j] = r_work;
      a = '0;
      b = '0;
      s = '0;
      d = '0;
      for (int i = 0; i < M / 2; i++) begin
        a = r_work[PIX_W*(B+2*i) +: PIX_W];
        b = r_work[PIX_W*(B+2*i+1) +: PIX_W];
        s = {1'b0, a} + {1'b0, b};
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        w_res[j][PIX_W*(B+M/2+i) +: PIX_W] = PIX_W'(s >> 1);
        w_res[j][PIX_W*(B+i) +: PIX_W] = PIX_W'(d >>> 1);
      end
    end
  end

  always_comb begin
    w_next = w_res[0];
    for (int k = 0; k < LEVELS; k++) begin
      if (r_lvl == 3'(k + 1)) w_next = w_res[k];
    end
  end

  always_comb begin
    w_depth = levels;
    unique case (1'b1)
      (levels == 3'd0): w_depth = 3'd1;
      (levels > LMAX):  w_depth = LMAX;
      default:          w_depth = levels;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_lvl       <= '0;
      r_depth     <= '0;
      r_work      <= '0;
      r_pix_out   <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_work     <= pixel;
            r_depth    <= w_depth;
            r_lvl      <= 3'd1;
            r_state    <= CALC;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        CALC: begin
          r_work <= w_next;
          if (r_lvl == r_depth) begin
            r_pix_out   <= w_next;
            r_out_valid <= 1'b1;
            r_state     <= HOLD;
          end else begin
            r_lvl <= r_lvl + 3'd1;
          end
        end
        HOLD: begin
          // in_ready rises only once back in IDLE
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign pix_out   = r_pix_out;
  assign busy      = r_busy;

endmodule
